// File: rtl/rx_frame_splitter_if.sv
// ---------------------------------------------------------------------------
// rx_frame_splitter_if
// Groups the RX MAC byte stream and the header/body FIFO write ports that
// surround the frame splitter.
//   rx_valid/rx_data/rx_last/rx_err : MAC byte stream (cannot be stalled)
//   h_fifo_din/h_fifo_wren          : header word push, h_fifo_full = no slot
//   b_fifo_din/b_fifo_wren          : body byte push ([8] = delimiter)
//   b_fifo_afull                    : body FIFO cannot take a full frame
// Modports:
//   master : the environment (MAC source + FIFO status)
//   slave  : the splitter itself
// ---------------------------------------------------------------------------
interface rx_frame_splitter_if #(
  parameter int HEADER_DWIDTH = 128
);
  logic                     rx_valid;
  logic [7:0]               rx_data;
  logic                     rx_last;
  logic                     rx_err;
  logic [HEADER_DWIDTH-1:0] h_fifo_din;
  logic                     h_fifo_wren;
  logic                     h_fifo_full;
  logic [8:0]               b_fifo_din;
  logic                     b_fifo_wren;
  logic                     b_fifo_afull;

  modport master (
    output rx_valid, rx_data, rx_last, rx_err, h_fifo_full, b_fifo_afull,
    input  h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_wren
  );

  modport slave (
    input  rx_valid, rx_data, rx_last, rx_err, h_fifo_full, b_fifo_afull,
    output h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_wren
  );
endinterface

// File: rtl/rx_frame_splitter.sv
// ---------------------------------------------------------------------------
// rx_frame_splitter
// Parses each Ethernet frame from the RX MAC byte stream, checks its CRC-32,
// pushes the first 14 bytes plus status as one header word and writes the
// remaining bytes (delimiter-tagged) into the body FIFO.
// Ports:
//   clk      : system clock
//   arst     : asynchronous active-high reset
//   bus      : stream + FIFO write ports (slave modport)
//   drop_cnt : saturating count of frames dropped without any FIFO write
// Header word: [127:116] stored length, [115] fcs_ok, [114] is_ctrl,
//   [113:112] 0, [111:64] dst MAC, [63:16] src MAC, [15:0] EtherType.
// ---------------------------------------------------------------------------
module rx_frame_splitter #(
  parameter int HEADER_DWIDTH = 128,
  parameter int MAX_LEN       = 1518
) (
  input  logic                 clk,
  input  logic                 arst,
  rx_frame_splitter_if.slave   bus,
  output logic [15:0]          drop_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY,
    ST_TRUNC,
    ST_DROP
  } state_t;

  localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);
  localparam logic [10:0] HDR_LAST  = 11'd13;
  localparam logic [10:0] MIN_LEN   = 11'd64;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESID = 32'hDEBB_20E3;

  state_t                   state_reg, state_next;
  logic [10:0]              cnt_reg, cnt_next;     // bytes already accepted in this frame
  logic [31:0]              crc_reg, crc_next;
  logic                     err_reg, err_next;
  logic [111:0]             hdr_reg, hdr_next;     // bytes 0..13, byte 0 ends up at the top
  logic [HEADER_DWIDTH-1:0] h_din_reg, h_din_next;
  logic                     h_wren_reg, h_wren_next;
  logic [8:0]               b_din_reg, b_din_next;
  logic                     b_wren_reg, b_wren_next;
  logic [15:0]              drop_reg, drop_next;

  // One byte of the reflected CRC-32, LSB of the data first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  logic [31:0]              crc_upd;
  logic [10:0]              len_cur;   // frame length including the current byte, capped
  logic                     err_seen;
  logic                     fcs_ok;
  logic                     is_ctrl;
  logic                     start_busy;
  logic                     trunc_now;
  logic [15:0]              drop_inc;
  logic [HEADER_DWIDTH-1:0] hdr_word;

  assign crc_upd    = crc_byte(crc_reg, bus.rx_data);
  assign len_cur    = (cnt_reg == MAX_LEN_W) ? MAX_LEN_W : cnt_reg + 11'd1;
  assign err_seen   = err_reg | bus.rx_err;
  // Only a frame that finishes cleanly in BODY can be good; TRUNC always reports bad.
  assign fcs_ok     = (state_reg == ST_BODY) && (crc_upd == CRC_RESID) && !err_seen &&
                      (len_cur >= MIN_LEN) && (len_cur <= MAX_LEN_W);
  assign is_ctrl    = (hdr_reg[111:72] == 40'h01_80C2_0000);
  assign start_busy = bus.h_fifo_full | bus.b_fifo_afull;
  assign trunc_now  = (cnt_reg == MAX_LEN_W - 11'd1) && !bus.rx_last;
  assign drop_inc   = (drop_reg == 16'hFFFF) ? drop_reg : drop_reg + 16'd1;
  assign hdr_word   = HEADER_DWIDTH'({1'b0, len_cur, fcs_ok, is_ctrl, 2'b00, hdr_reg});

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      crc_reg    <= CRC_INIT;
      err_reg    <= 1'b0;
      hdr_reg    <= '0;
      h_din_reg  <= '0;
      h_wren_reg <= 1'b0;
      b_din_reg  <= '0;
      b_wren_reg <= 1'b0;
      drop_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      crc_reg    <= crc_next;
      err_reg    <= err_next;
      hdr_reg    <= hdr_next;
      h_din_reg  <= h_din_next;
      h_wren_reg <= h_wren_next;
      b_din_reg  <= b_din_next;
      b_wren_reg <= b_wren_next;
      drop_reg   <= drop_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    crc_next    = crc_reg;
    err_next    = err_reg;
    hdr_next    = hdr_reg;
    h_din_next  = h_din_reg;
    h_wren_next = 1'b0;
    b_din_next  = b_din_reg;
    b_wren_next = 1'b0;
    drop_next   = drop_reg;

    if (bus.rx_valid) begin
      crc_next = crc_upd;
      err_next = err_seen;
      cnt_next = len_cur;

      unique case (state_reg)
        ST_IDLE: begin
          if (bus.rx_last) begin
            drop_next = drop_inc;
          end else if (start_busy) begin
            state_next = ST_DROP;
          end else begin
            hdr_next   = {hdr_reg[103:0], bus.rx_data};
            state_next = ST_HDR;
          end
        end
        ST_HDR: begin
          hdr_next = {hdr_reg[103:0], bus.rx_data};
          if (bus.rx_last) begin
            drop_next = drop_inc;
          end else if (cnt_reg == HDR_LAST) begin
            state_next = ST_BODY;
          end
        end
        ST_BODY: begin
          b_wren_next = 1'b1;
          b_din_next  = {bus.rx_last | trunc_now, bus.rx_data};
          if (bus.rx_last) begin
            h_wren_next = 1'b1;
            h_din_next  = hdr_word;
          end else if (trunc_now) begin
            state_next = ST_TRUNC;
          end
        end
        ST_TRUNC: begin
          if (bus.rx_last) begin
            h_wren_next = 1'b1;
            h_din_next  = hdr_word;
          end
        end
        ST_DROP: begin
          if (bus.rx_last) begin
            drop_next = drop_inc;
          end
        end
        default: state_next = ST_IDLE;
      endcase

      // Every frame end re-arms the per-frame state so the next byte can start a frame.
      if (bus.rx_last) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        crc_next   = CRC_INIT;
        err_next   = 1'b0;
      end
    end
  end

  assign bus.h_fifo_din  = h_din_reg;
  assign bus.h_fifo_wren = h_wren_reg;
  assign bus.b_fifo_din  = b_din_reg;
  assign bus.b_fifo_wren = b_wren_reg;
  assign drop_cnt        = drop_reg;

endmodule

// File: tb/tb_rx_frame_splitter.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_splitter
// Scoreboard bench: each frame is turned into expected header words, body
// bytes and drop-counter values by a frame-level reference model; a monitor
// pops and compares whenever the DUT writes a FIFO or moves drop_cnt.
// ---------------------------------------------------------------------------
module tb_rx_frame_splitter;
  localparam int MAX_LEN = 1518;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [15:0] drop_cnt;

  rx_frame_splitter_if #(.HEADER_DWIDTH(128)) bus();

  rx_frame_splitter #(.HEADER_DWIDTH(128), .MAX_LEN(MAX_LEN)) dut (
    .clk      (clk),
    .arst     (arst),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] hdr;
    logic         delim;   // delimiter byte expected in the same cycle
  } hexp_t;

  hexp_t       h_exp[$];
  logic [8:0]  b_exp[$];
  logic [15:0] d_exp[$];
  logic [7:0]  frm[$];
  int          hcyc[$];

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          bcnt = 0;
  int          dcnt = 0;
  bit          mon_en = 1'b0;
  logic [15:0] drop_prev = '0;
  logic [15:0] exp_drop = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    n_checks++;
    $display("FAIL %s: unexpected output %h with nothing expected", name, act);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    hexp_t e;
    if (!arst && mon_en) begin
      if (bus.b_fifo_wren) begin
        bcnt++;
        if (bus.b_fifo_din[8]) dcnt++;
        if (b_exp.size() == 0) unexpected("body_write", 128'(bus.b_fifo_din));
        else check("body_byte", 128'(bus.b_fifo_din), 128'(b_exp.pop_front()));
      end
      if (bus.h_fifo_wren) begin
        hcyc.push_back(cyc);
        if (h_exp.size() == 0) unexpected("hdr_write", bus.h_fifo_din);
        else begin
          e = h_exp.pop_front();
          check("hdr_word", bus.h_fifo_din, e.hdr);
          check("hdr_delim_same_cycle", 128'(bus.b_fifo_wren & bus.b_fifo_din[8]), 128'(e.delim));
        end
      end
      if (drop_cnt !== drop_prev) begin
        if (d_exp.size() == 0) unexpected("drop_cnt", 128'(drop_cnt));
        else check("drop_cnt", 128'(drop_cnt), 128'(d_exp.pop_front()));
        drop_prev = drop_cnt;
      end
    end
  end

  // Standard Ethernet CRC-32 of frm[0..n-1] (final value, already inverted).
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ frm[i][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return ~c;
  endfunction

  task automatic build_frame(input int len, input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] etype, input bit good);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6)       b = dst[47-8*i -: 8];
      else if (i < 12) b = src[47-8*(i-6) -: 8];
      else if (i == 12) b = etype[15:8];
      else if (i == 13) b = etype[7:0];
      else             b = 8'($urandom);
      frm.push_back(b);
    end
    if (good && len >= 18) begin
      c = ref_crc(len - 4);
      frm[len-4] = c[7:0];
      frm[len-3] = c[15:8];
      frm[len-2] = c[23:16];
      frm[len-1] = c[31:24];
    end
  endtask

  // Frame-level reference: what the splitter must emit for frm.
  task automatic model_frame(input bit start_busy, input int err_pos);
    int           len, stored;
    bit           err, crc_good, ok, ctrl;
    logic [31:0]  fcs;
    logic [111:0] hb;
    hexp_t        e;
    len    = frm.size();
    stored = (len > MAX_LEN) ? MAX_LEN : len;
    if (start_busy || len <= 14) begin
      if (exp_drop != 16'hFFFF) exp_drop++;
      d_exp.push_back(exp_drop);
      return;
    end
    for (int i = 14; i < stored; i++) b_exp.push_back({(i == stored - 1), frm[i]});
    err = (err_pos >= 0) && (err_pos < len);
    fcs = {frm[len-1], frm[len-2], frm[len-3], frm[len-4]};
    crc_good = (ref_crc(len - 4) == fcs);
    ok   = crc_good && !err && (len >= 64) && (len <= MAX_LEN);
    ctrl = (frm[0] == 8'h01) && (frm[1] == 8'h80) && (frm[2] == 8'hC2) &&
           (frm[3] == 8'h00) && (frm[4] == 8'h00);
    for (int i = 0; i < 14; i++) hb[111-8*i -: 8] = frm[i];
    e.hdr   = {12'(stored), ok, ctrl, 2'b00, hb};
    e.delim = (len <= MAX_LEN);
    h_exp.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0; bus.rx_last = 1'b0; bus.rx_err = 1'b0;
      bus.b_fifo_afull = 1'b0; bus.h_fifo_full = 1'b0;
    end
  endtask

  // Drives frm; leaves the last byte on the bus so a following frame can be back-to-back.
  task automatic send_frame(input bit afull_first, input bit hfull_first,
                            input int gap_max, input int err_pos);
    int len;
    len = frm.size();
    model_frame(afull_first | hfull_first, err_pos);
    for (int i = 0; i < len; i++) begin
      if (gap_max > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, gap_max));
      @(negedge clk);
      bus.rx_valid     = 1'b1;
      bus.rx_data      = frm[i];
      bus.rx_last      = (i == len - 1);
      bus.rx_err       = (i == err_pos);
      bus.b_fifo_afull = afull_first && (i == 0);
      bus.h_fifo_full  = hfull_first && (i == 0);
    end
  endtask

  task automatic drain();
    int t = 0;
    idle(1);
    while ((h_exp.size() != 0 || b_exp.size() != 0 || d_exp.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d hdr %0d body %0d drop still pending",
               h_exp.size(), b_exp.size(), d_exp.size());
    end
    idle(3);
  endtask

  localparam logic [47:0] CTRL_DST = 48'h0180_C200_0000;
  localparam logic [47:0] UC_DST   = 48'h0011_2233_4455;
  localparam logic [47:0] SRC_MAC  = 48'h0A0B_0C0D_0E0F;

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.rx_last = 1'b0; bus.rx_err = 1'b0;
    bus.h_fifo_full = 1'b0; bus.b_fifo_afull = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_h_wren", 128'(bus.h_fifo_wren), 128'd0);
    check("rst_b_wren", 128'(bus.b_fifo_wren), 128'd0);
    check("rst_h_din",  bus.h_fifo_din, 128'd0);
    check("rst_b_din",  128'(bus.b_fifo_din), 128'd0);
    check("rst_drop",   128'(drop_cnt), 128'd0);
    arst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // 1: 64-byte control frame, good FCS
    bcnt = 0;
    build_frame(64, CTRL_DST, SRC_MAC, 16'h8808, 1'b1);
    send_frame(0, 0, 0, -1);
    drain();
    check("t1_body_writes", 128'(bcnt), 128'd50);

    // 2: same frame with byte 20 flipped
    bcnt = 0;
    build_frame(64, CTRL_DST, SRC_MAC, 16'h8808, 1'b1);
    frm[20] = frm[20] ^ 8'h5A;
    send_frame(0, 0, 0, -1);
    drain();
    check("t2_body_writes", 128'(bcnt), 128'd50);

    // 3: 100-byte unicast IPv4 frame with idle gaps inside
    bcnt = 0;
    build_frame(100, UC_DST, SRC_MAC, 16'h0800, 1'b1);
    send_frame(0, 0, 3, -1);
    drain();
    check("t3_body_writes", 128'(bcnt), 128'd86);

    // 4: body FIFO almost full at frame start, then a runt
    bcnt = 0;
    build_frame(64, UC_DST, SRC_MAC, 16'h0800, 1'b1);
    send_frame(1, 0, 0, -1);
    build_frame(10, UC_DST, SRC_MAC, 16'h0800, 1'b0);
    send_frame(0, 0, 0, -1);
    drain();
    check("t4_body_writes", 128'(bcnt), 128'd0);
    check("t4_drop_cnt", 128'(drop_cnt), 128'd2);

    // 5: oversize frame is truncated
    bcnt = 0; dcnt = 0;
    build_frame(1600, UC_DST, SRC_MAC, 16'h0800, 1'b1);
    send_frame(0, 0, 0, -1);
    drain();
    check("t5_body_writes", 128'(bcnt), 128'd1504);
    check("t5_delims", 128'(dcnt), 128'd1);

    // 6: two good frames with no gap
    bcnt = 0; dcnt = 0; hcyc.delete();
    build_frame(64, CTRL_DST, SRC_MAC, 16'h8808, 1'b1);
    send_frame(0, 0, 0, -1);
    build_frame(64, UC_DST, SRC_MAC, 16'h0800, 1'b1);
    send_frame(0, 0, 0, -1);
    drain();
    check("t6_body_writes", 128'(bcnt), 128'd100);
    check("t6_delims", 128'(dcnt), 128'd2);
    check("t6_hdr_pushes", 128'(hcyc.size()), 128'd2);
    if (hcyc.size() == 2) check("t6_hdr_spacing", 128'(hcyc[1] - hcyc[0]), 128'd64);

    // Length boundaries: exactly MAX_LEN, one over, shortest body, header-only
    build_frame(MAX_LEN, UC_DST, SRC_MAC, 16'h0800, 1'b1);
    send_frame(0, 0, 0, -1);
    build_frame(MAX_LEN + 1, UC_DST, SRC_MAC, 16'h0800, 1'b1);
    send_frame(0, 0, 0, -1);
    build_frame(15, UC_DST, SRC_MAC, 16'h0800, 1'b1);
    send_frame(0, 0, 0, -1);
    build_frame(14, UC_DST, SRC_MAC, 16'h0800, 1'b1);
    send_frame(0, 0, 0, -1);
    build_frame(64, CTRL_DST, SRC_MAC, 16'h8808, 1'b1);
    send_frame(0, 1, 0, 63);
    build_frame(64, UC_DST, SRC_MAC, 16'h0800, 1'b1);
    send_frame(0, 0, 0, 63);
    drain();

    // Randomised frames
    for (int n = 0; n < 30; n++) begin
      int          len, err_pos;
      logic [47:0] dst;
      dst = ($urandom_range(0, 2) == 0) ? {40'h01_80C2_0000, 8'($urandom)} :
                                          {16'($urandom), 32'($urandom)};
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 80) : $urandom_range(60, 220);
      err_pos = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      build_frame(len, dst, SRC_MAC, 16'($urandom), $urandom_range(0, 3) != 0);
      send_frame($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 1) == 0) ? 0 : 3, err_pos);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
    end
    drain();
    check("final_drop_cnt", 128'(drop_cnt), 128'(exp_drop));

    // Reset in the middle of a frame
    mon_en = 1'b0;
    build_frame(64, UC_DST, SRC_MAC, 16'h0800, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b1; bus.rx_data = frm[i]; bus.rx_last = 1'b0; bus.rx_err = 1'b0;
    end
    @(posedge clk);
    #2 arst = 1'b1;
    #1;
    check("midrst_b_wren", 128'(bus.b_fifo_wren), 128'd0);
    check("midrst_b_din",  128'(bus.b_fifo_din), 128'd0);
    check("midrst_drop",   128'(drop_cnt), 128'd0);
    idle(2);
    arst = 1'b0;
    drop_prev = '0;
    exp_drop = '0;
    mon_en = 1'b1;
    idle(1);
    bcnt = 0;
    build_frame(64, CTRL_DST, SRC_MAC, 16'h8808, 1'b1);
    send_frame(0, 0, 0, -1);
    drain();
    check("post_rst_body_writes", 128'(bcnt), 128'd50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_splitter.md
# rx_frame_splitter

Ingress stage of the L2 switch, between the RX MAC byte stream and the per-port Header FIFO / Body FIFO pair. It parses each Ethernet frame and checks its CRC-32. It pushes the first 14 bytes plus status as one 128-bit header word, and writes the remaining bytes, delimiter-tagged, into the body FIFO. Control-frame fetch and forwarding logic downstream consume these FIFOs.

## Interface
- HEADER_DWIDTH, 128: header word width (fixed layout below).
- MAX_LEN, 1518: maximum stored frame length in bytes, including FCS.
- clk  in  1  system clock.
- arst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  rx_data valid this cycle; the stream cannot be stalled.
- rx_data  in  8  frame byte, destination MAC first, FCS last.
- rx_last  in  1  last byte of frame; qualified by rx_valid.
- rx_err  in  1  MAC error; sampled on any valid byte, sticky per frame.
- h_fifo_din  out  128  header word.
- h_fifo_wren  out  1  one-cycle header push.
- h_fifo_full  in  1  header FIFO has no free slot.
- b_fifo_din  out  9  [8] delimiter (last stored byte of frame), [7:0] byte.
- b_fifo_wren  out  1  body byte push.
- b_fifo_afull  in  1  fewer than MAX_LEN free body entries.
- drop_cnt  out  16  dropped-frame counter; saturates at 0xFFFF.

## Operation
- Header layout:
  - [127:116] stored length in bytes: total received, capped at MAX_LEN.
  - [115] fcs_ok: 1 only if the CRC residue matches, rx_err was never seen, 64 ≤ length ≤ MAX_LEN, and the frame was not truncated.
  - [114] is_ctrl: dst MAC[47:8] == 48'h0180C200_00 (top 40 bits).
  - [113:112] 0.
  - [111:64] dst MAC; first byte in [111:104].
  - [63:16] src MAC.
  - [15:0] EtherType; byte 12 in [15:8].
- CRC: reflected polynomial 0xEDB88320, LSB first, initialised to 0xFFFFFFFF at each frame start. It runs over every byte including the FCS. The FCS is good when the register equals 0xDEBB20E3 after the last byte, computed combinationally with that byte.
- Byte index counter: 11 bits; it stops incrementing at MAX_LEN.
- States:
  - IDLE: the first valid byte starts a frame. If h_fifo_full or b_fifo_afull is set → DROP. Otherwise → HDR with byte 0 captured.
  - HDR: capture bytes 0..13 into the header shift register. Byte 13 → BODY.
  - BODY: write each byte to the body FIFO. Byte index MAX_LEN-1 without rx_last is written with del=1 and the frame is marked truncated → TRUNC.
  - TRUNC: discard bytes until rx_last, then push the header with fcs_ok=0 and length=MAX_LEN → IDLE.
  - DROP: discard bytes until rx_last, then increment drop_cnt → IDLE. Nothing is written to either FIFO.
- rx_last in IDLE or HDR (length ≤ 14): no writes, drop_cnt++, → IDLE.
- rx_last in BODY: the byte is written with del=1, the header is pushed, → IDLE.
- Lengths 15..63 are pushed with fcs_ok=0, so the consumer always sees a delimiter.
- The FIFO-space check happens only at frame start. This block is the sole writer, so the reserved space persists for the rest of the frame.

## Timing
- Reset: state IDLE; CRC 0xFFFFFFFF; counters 0; h_fifo_wren, b_fifo_wren, h_fifo_din, b_fifo_din and drop_cnt all 0.
- Body byte accepted in cycle N → b_fifo_wren=1 in cycle N+1 (registered).
- rx_last accepted in cycle N → h_fifo_wren=1 for exactly cycle N+1, same cycle as the delimiter byte write.
- Back-to-back frames (new byte in cycle N+1) are fully supported; there is no dead cycle.
- drop_cnt updates in cycle N+1 after the terminating rx_last.
- Cycles with rx_valid=0 inside a frame hold all state.
- Reset mid-frame aborts the frame immediately. A partial body left without a delimiter is cleared by the system-wide FIFO reset.

## Test plan
1. 64-byte frame to 01:80:C2:00:00:00 with valid FCS → 50 body writes, last with [8]=1; header [127:116]=64, [115]=1, [114]=1, [111:64]=0x0180C2000000.
2. Same frame with byte 20 flipped → identical write counts; header [115]=0.
3. 100-byte unicast frame to 00:11:22:33:44:55, EtherType 0x0800 → 86 body writes; header [114]=0, [15:0]=0x0800, length 100.
4. b_fifo_afull=1 on the first byte of a 64-byte frame → no FIFO writes, drop_cnt 0→1; then a 10-byte frame → drop_cnt 2.
5. 1600-byte frame → 1504 body writes, the 1504th with del=1; header length 1518, [115]=0; no writes for the remaining 82 bytes.
6. Two valid 64-byte frames with zero gap → two header pushes 64 cycles apart, both [115]=1; 100 body writes in total with exactly two delimiters.
